// File: rtl/data_router_pkg.sv
// rtl/data_router_pkg.sv - shared bank index type, limits and wrapping pointer helper
package data_router_pkg;

  localparam int BANK_W  = 2;
  localparam int MAX_POY = 4;

  typedef logic [BANK_W-1:0] bank_idx_t;

  // Advance a bank pointer by one, wrapping from poy-1 back to 0 by comparison
  function automatic bank_idx_t next_bank(input bank_idx_t ptr, input int unsigned poy);
    if (ptr == bank_idx_t'(poy - 1)) begin
      return '0;
    end
    return ptr + bank_idx_t'(1);
  endfunction

endpackage

// File: rtl/bank_ptr_ctrl.sv
// rtl/bank_ptr_ctrl.sv - write/read bank pointers, column counter and row occupancy
module bank_ptr_ctrl
  import data_router_pkg::*;
#(
  parameter int POY  = 3,
  parameter int BUFW = 32,
  localparam int COL_W = $clog2(BUFW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             wr_en,
  output bank_idx_t        wr_bank,
  output logic [COL_W-1:0] wr_col,
  output bank_idx_t        rd_bank,
  output logic             out_valid,
  output logic [2:0]       occ
);

  typedef logic [COL_W-1:0] col_t;

  bank_idx_t  wr_bank_q, wr_bank_d;
  bank_idx_t  rd_bank_q, rd_bank_d;
  col_t       col_q, col_d;
  logic [2:0] occ_q, occ_d;

  logic accept;
  logic row_done;
  logic pop;

  // Handshake decode and next-state for pointers, column and occupancy
  always_comb begin
    in_ready  = rst_n && !clr && (occ_q < 3'(POY));
    out_valid = (occ_q != 3'd0);
    accept    = in_valid && in_ready;
    row_done  = accept && (col_q == col_t'(BUFW - 1));
    pop       = out_valid && out_ready && !clr;

    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    col_d     = col_q;
    occ_d     = occ_q;

    if (clr) begin
      wr_bank_d = '0;
      rd_bank_d = '0;
      col_d     = '0;
      occ_d     = '0;
    end else begin
      if (accept) begin
        if (row_done) begin
          col_d     = '0;
          wr_bank_d = next_bank(wr_bank_q, POY);
        end else begin
          col_d = col_q + col_t'(1);
        end
      end
      if (pop) begin
        rd_bank_d = next_bank(rd_bank_q, POY);
      end
      case ({row_done, pop})
        2'b10:   occ_d = occ_q + 3'd1;
        2'b01:   occ_d = occ_q - 3'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Pointer and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q <= '0;
      rd_bank_q <= '0;
      col_q     <= '0;
      occ_q     <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      col_q     <= col_d;
      occ_q     <= occ_d;
    end
  end

  assign wr_en   = accept;
  assign wr_bank = wr_bank_q;
  assign wr_col  = col_q;
  assign rd_bank = rd_bank_q;
  assign occ     = occ_q;

endmodule

// File: rtl/bank_row_writer.sv
// rtl/bank_row_writer.sv - packs a word stream into rows held in circular banks
module bank_row_writer
  import data_router_pkg::*;
#(
  parameter int DW   = 1,
  parameter int POY  = 3,
  parameter int BUFW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] bank_data [POY][BUFW],
  output logic [1:0]    bank,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    occupancy
);

  localparam int COL_W = $clog2(BUFW);
  typedef logic [COL_W-1:0] col_t;

  if (POY < 2 || POY > MAX_POY || BUFW < 2) begin : g_bad_params
    $error("bank_row_writer: POY must be 2..MAX_POY and BUFW at least 2");
  end

  logic       wr_en;
  bank_idx_t  wr_bank;
  col_t       wr_col;
  bank_idx_t  rd_bank;
  logic [2:0] occ;

  logic [DW-1:0] mem_q [POY][BUFW];
  logic [DW-1:0] mem_d [POY][BUFW];

  bank_ptr_ctrl #(
    .POY  (POY),
    .BUFW (BUFW)
  ) u_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_bank   (wr_bank),
    .wr_col    (wr_col),
    .rd_bank   (rd_bank),
    .out_valid (out_valid),
    .occ       (occ)
  );

  // Write decode: only the addressed word of the bank being filled changes
  always_comb begin
    mem_d = mem_q;
    for (int b = 0; b < POY; b++) begin
      for (int c = 0; c < BUFW; c++) begin
        if (wr_en && (wr_bank == bank_idx_t'(b)) && (wr_col == col_t'(c))) begin
          mem_d[b][c] = in_data;
        end
      end
    end
  end

  // Row storage; cleared only by reset, never by clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < POY; b++) begin
        for (int c = 0; c < BUFW; c++) begin
          mem_q[b][c] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign bank_data = mem_q;
  assign bank      = rd_bank;
  assign occupancy = occ;

endmodule
